// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
//   state_e        : scanner FSM states
//   ROWS_IDLE      : row pattern with no key pulling any row low
//   COL_PATTERN    : one-hot-low column drive, indexed by column number
//   key_lookup     : row/column to hex key code
//   lowest_low_row : index of the lowest-numbered row that is low
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2
   } state_e;

   localparam logic [3:0] ROWS_IDLE = 4'b1111;

   // Element [c] drives column c low.
   localparam logic [3:0][3:0] COL_PATTERN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

   // Keypad legend:  r0: 1 2 3 A / r1: 4 5 6 B / r2: 7 8 9 C / r3: 0 F E D
   function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'h0;
         4'b11_01: code = 4'hF;
         4'b11_10: code = 4'hE;
         4'b11_11: code = 4'hD;
      endcase
      return code;
   endfunction

   // Scanning from the top down leaves the lowest low index as the result.
   function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan tick generator: one-clk pulse every SCAN_DIV clocks.
//   clk  : system clock
//   rst  : synchronous active-low reset
//   tick : high for one clk when the internal counter sits at SCAN_DIV-1
module keypad_tick_gen #(
   parameter int unsigned SCAN_DIV = 100000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned     CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // Tick is registered from the next count so it coincides with cnt_q == CNT_MAX.
   always_comb begin
      cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + CNT_W'(1);
      tick_d = (cnt_d == CNT_MAX);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with debounce and a single-entry key register.
//   clk       : system clock
//   rst       : synchronous active-low reset
//   row       : matrix rows, active-low, asynchronous to clk
//   key_ack   : one-clk pulse, CPU consumed the key
//   column    : column drive, one-hot low
//   key_code  : hex code of the last accepted key
//   key_valid : key available, cleared by key_ack
//   overrun   : sticky, a key arrived while the previous one was unread
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 100000,
   parameter int unsigned DEBOUNCE_TICKS = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   input  logic       key_ack,
   output logic [3:0] column,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       overrun
);

   localparam int unsigned      DCNT_W   = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [DCNT_W-1:0] DCNT_TGT = DCNT_W'(DEBOUNCE_TICKS);

   logic              tick;
   logic [3:0]        row_meta_q, row_s_q;
   state_e            state_q, state_d;
   logic [1:0]        col_idx_q, col_idx_d;
   logic [1:0]        row_idx_q, row_idx_d;
   logic [DCNT_W-1:0] dcnt_q, dcnt_d, dcnt_inc;
   logic              accept_c;
   logic [3:0]        column_q, column_d;
   logic [3:0]        key_code_q, key_code_d;
   logic              key_valid_q, key_valid_d;
   logic              overrun_q, overrun_d;

   keypad_tick_gen #(
      .SCAN_DIV(SCAN_DIV)
   ) u_tick_gen (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   assign dcnt_inc = dcnt_q + DCNT_W'(1);

   // State and output registers, including the 2-flop row synchronizer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         row_meta_q  <= ROWS_IDLE;
         row_s_q     <= ROWS_IDLE;
         state_q     <= SCAN;
         col_idx_q   <= 2'd0;
         row_idx_q   <= 2'd0;
         dcnt_q      <= '0;
         column_q    <= COL_PATTERN[0];
         key_code_q  <= 4'h0;
         key_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         row_meta_q  <= row;
         row_s_q     <= row_meta_q;
         state_q     <= state_d;
         col_idx_q   <= col_idx_d;
         row_idx_q   <= row_idx_d;
         dcnt_q      <= dcnt_d;
         column_q    <= column_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   // Next-state: all decisions are taken on tick cycles only.
   always_comb begin
      state_d   = state_q;
      col_idx_d = col_idx_q;
      row_idx_d = row_idx_q;
      dcnt_d    = dcnt_q;
      accept_c  = 1'b0;
      if (tick) begin
         unique case (state_q)
            SCAN: begin
               if (row_s_q == ROWS_IDLE) begin
                  col_idx_d = col_idx_q + 2'd1;
               end else begin
                  row_idx_d = lowest_low_row(row_s_q);
                  if (DEBOUNCE_TICKS == 1) begin
                     accept_c = 1'b1;
                     dcnt_d   = '0;
                     state_d  = HELD;
                  end else begin
                     dcnt_d  = DCNT_W'(1);
                     state_d = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (!row_s_q[row_idx_q]) begin
                  if (dcnt_inc == DCNT_TGT) begin
                     accept_c = 1'b1;
                     dcnt_d   = '0;
                     state_d  = HELD;
                  end else begin
                     dcnt_d = dcnt_inc;
                  end
               end else begin
                  dcnt_d    = '0;
                  col_idx_d = col_idx_q + 2'd1;
                  state_d   = SCAN;
               end
            end
            HELD: begin
               // Any low row restarts the release count.
               if (row_s_q == ROWS_IDLE) begin
                  if (dcnt_inc == DCNT_TGT) begin
                     dcnt_d    = '0;
                     col_idx_d = col_idx_q + 2'd1;
                     state_d   = SCAN;
                  end else begin
                     dcnt_d = dcnt_inc;
                  end
               end else begin
                  dcnt_d = '0;
               end
            end
            default: begin
               state_d = SCAN;
            end
         endcase
      end
   end

   // Outputs: column follows the scan index; accept/ack arbitration for the key register.
   always_comb begin
      column_d    = COL_PATTERN[col_idx_d];
      key_code_d  = key_code_q;
      key_valid_d = key_valid_q;
      overrun_d   = overrun_q;
      if (accept_c) begin
         if (!key_valid_q || key_ack) begin
            key_code_d  = key_lookup(row_idx_d, col_idx_q);
            key_valid_d = 1'b1;
            if (key_ack) overrun_d = 1'b0;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (key_ack) begin
         key_valid_d = 1'b0;
         overrun_d   = 1'b0;
      end
   end

   assign column    = column_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: directed scenarios followed by random key activity,
// compared every cycle against a tick-level behavioural model of the keypad.
module tb_keypad_scanner;

   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned DT       = 3;
   localparam int PH_SCAN = 0;
   localparam int PH_CONF = 1;
   localparam int PH_HOLD = 2;

   logic        clk     = 1'b0;
   logic        rst     = 1'b0;
   logic        key_ack = 1'b0;
   logic [3:0]  row;
   logic [3:0]  column;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        overrun;

   logic [15:0] press    = '0;     // bit r*4+c: key at row r, column c held down
   logic        ovr_en   = 1'b0;   // drive rows directly instead of via the matrix
   logic [3:0]  ovr_rows = 4'hF;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   keypad_scanner #(
      .SCAN_DIV      (SCAN_DIV),
      .DEBOUNCE_TICKS(DT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .row      (row),
      .key_ack  (key_ack),
      .column   (column),
      .key_code (key_code),
      .key_valid(key_valid),
      .overrun  (overrun)
   );

   // Passive matrix: a pressed key shorts its row to its column when that column is driven low.
   function automatic logic [3:0] matrix_rows(input logic [3:0] col, input logic [15:0] keys);
      logic [3:0] rows;
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && col[c] === 1'b0) rows[r] = 1'b0;
      return rows;
   endfunction

   assign row = ovr_en ? ovr_rows : matrix_rows(column, press);

   // ---------------- reference model ----------------
   int keymap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{0, 15, 14, 13}};

   int         m_cnt   = 0;
   logic [3:0] m_s1    = 4'hF;
   logic [3:0] m_s2    = 4'hF;
   int         m_c     = 0;
   int         m_r     = 0;
   int         m_phase = PH_SCAN;
   int         m_run   = 0;
   logic [3:0] e_col   = 4'b1110;
   logic [3:0] e_code  = 4'h0;
   logic       e_valid = 1'b0;
   logic       e_ovr   = 1'b0;

   function automatic int first_low(input logic [3:0] rs);
      int idx;
      idx = 0;
      for (int i = 3; i >= 0; i--) if (!rs[i]) idx = i;
      return idx;
   endfunction

   always @(posedge clk) begin : model_b
      logic [3:0] rs;
      bit         tk;
      bit         acc;
      if (!rst) begin
         m_cnt = 0; m_s1 = 4'hF; m_s2 = 4'hF;
         m_c = 0; m_r = 0; m_phase = PH_SCAN; m_run = 0;
         e_col = 4'b1110; e_code = 4'h0; e_valid = 1'b0; e_ovr = 1'b0;
      end else begin
         rs    = m_s2;
         tk    = (m_cnt == SCAN_DIV - 1);
         m_cnt = (m_cnt + 1) % SCAN_DIV;
         m_s2  = m_s1;
         m_s1  = row;
         acc   = 1'b0;
         if (tk) begin
            if (m_phase == PH_SCAN) begin
               if (rs == 4'hF) m_c = (m_c + 1) % 4;
               else begin
                  m_r = first_low(rs); m_run = 1; m_phase = PH_CONF;
                  if (m_run >= DT) begin acc = 1'b1; m_run = 0; m_phase = PH_HOLD; end
               end
            end else if (m_phase == PH_CONF) begin
               if (!rs[m_r]) begin
                  m_run++;
                  if (m_run == DT) begin acc = 1'b1; m_run = 0; m_phase = PH_HOLD; end
               end else begin
                  m_run = 0; m_c = (m_c + 1) % 4; m_phase = PH_SCAN;
               end
            end else begin
               if (rs == 4'hF) begin
                  m_run++;
                  if (m_run == DT) begin m_run = 0; m_c = (m_c + 1) % 4; m_phase = PH_SCAN; end
               end else m_run = 0;
            end
         end
         if (acc) begin
            if (!e_valid || key_ack) begin
               e_code  = 4'(keymap[m_r][m_c]);
               e_valid = 1'b1;
               if (key_ack) e_ovr = 1'b0;
            end else e_ovr = 1'b1;
         end else if (key_ack) begin
            e_valid = 1'b0;
            e_ovr   = 1'b0;
         end
         e_col = ~(4'(1) << m_c);
      end
   end

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      chk("model_column",  column,          e_col);
      chk("model_code",    key_code,        e_code);
      chk("model_valid",   4'(key_valid),   4'(e_valid));
      chk("model_overrun", 4'(overrun),     4'(e_ovr));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_valid(input string tag, input int budget);
      int n;
      n = 0;
      while (key_valid !== 1'b1 && n < budget) begin step(); n++; end
      chk(tag, 4'(key_valid), 4'd1);
   endtask

   task automatic wait_col(input string tag, input logic [3:0] pat, input int budget);
      int n;
      n = 0;
      while (column !== pat && n < budget) begin step(); n++; end
      chk(tag, column, pat);
   endtask

   task automatic ack_pulse();
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      int n;

      // Reset and free-running scan
      steps(3);
      chk("reset_column", column, 4'b1110);
      chk("reset_valid",  4'(key_valid), 4'd0);
      chk("reset_code",   key_code, 4'h0);
      chk("reset_ovr",    4'(overrun), 4'd0);
      rst = 1'b1;
      steps(3);
      chk("scan_hold_c0", column, 4'b1110);
      step();
      chk("scan_c1", column, 4'b1101);
      steps(4);
      chk("scan_c2", column, 4'b1011);
      steps(4);
      chk("scan_c3", column, 4'b0111);
      steps(4);
      chk("scan_wrap", column, 4'b1110);

      // Clean press of '6' (r1, c2)
      press = 16'(1) << 6;
      wait_valid("press6_valid", 100);
      chk("press6_code",   key_code, 4'h6);
      chk("press6_column", column, 4'b1011);
      steps(8);
      chk("press6_frozen", column, 4'b1011);
      ack_pulse();
      chk("press6_ack", 4'(key_valid), 4'd0);
      steps(40);
      press = '0;
      wait_col("press6_resume", 4'b0111, 40);

      // Bounce on column 0, then steady '0' (r3, c0)
      wait_col("bounce_sync", 4'b1110, 40);
      ovr_en   = 1'b1;
      ovr_rows = 4'b0111;
      steps(4);
      chk("bounce_no_accept", 4'(key_valid), 4'd0);
      ovr_rows = 4'hF;
      steps(4);
      chk("bounce_abandon", column, 4'b1101);
      ovr_en = 1'b0;
      press  = 16'(1) << 12;
      wait_valid("key0_valid", 100);
      chk("key0_code",   key_code, 4'h0);
      chk("key0_column", column, 4'b1110);
      ack_pulse();
      press = '0;
      wait_col("key0_resume", 4'b1101, 40);

      // Overrun: '1' unread, then 'D'
      press = 16'(1) << 0;
      wait_valid("key1_valid", 100);
      chk("key1_code", key_code, 4'h1);
      press = '0;
      wait_col("key1_resume", 4'b1101, 40);
      press = 16'(1) << 15;
      n = 0;
      while (overrun !== 1'b1 && n < 100) begin step(); n++; end
      chk("ovr_set",   4'(overrun), 4'd1);
      chk("ovr_code",  key_code, 4'h1);
      chk("ovr_valid", 4'(key_valid), 4'd1);
      ack_pulse();
      chk("ovr_ack_valid", 4'(key_valid), 4'd0);
      chk("ovr_ack_ovr",   4'(overrun), 4'd0);
      press = '0;
      wait_col("keyD_resume", 4'b1110, 40);

      // Ack on the same clk as the accept of a second key
      press = 16'(1) << 5;
      wait_valid("key5_valid", 100);
      chk("key5_code", key_code, 4'h5);
      press = '0;
      wait_col("key5_resume", 4'b1011, 40);
      press = 16'(1) << 10;
      n = 0;
      while (!(m_phase == PH_CONF && m_run == DT - 1 && m_cnt == SCAN_DIV - 1) && n < 100) begin
         step(); n++;
      end
      ack_pulse();
      chk("coack_valid", 4'(key_valid), 4'd1);
      chk("coack_code",  key_code, 4'h9);
      chk("coack_ovr",   4'(overrun), 4'd0);

      // Short release inside HELD does not resume scanning
      press = '0;
      steps(8);
      press = 16'(1) << 10;
      steps(12);
      chk("short_rel_column", column, 4'b1011);
      chk("short_rel_code",   key_code, 4'h9);
      chk("short_rel_valid",  4'(key_valid), 4'd1);
      ack_pulse();
      press = '0;
      steps(8);
      chk("rel_two_ticks", column, 4'b1011);
      wait_col("rel_resume", 4'b0111, 8);

      // Reset while debouncing '2' (r0, c1)
      press = 16'(1) << 1;
      n = 0;
      while (m_phase != PH_CONF && n < 100) begin step(); n++; end
      rst = 1'b0;
      step();
      chk("midrst_column", column, 4'b1110);
      chk("midrst_valid",  4'(key_valid), 4'd0);
      chk("midrst_code",   key_code, 4'h0);
      chk("midrst_ovr",    4'(overrun), 4'd0);
      rst   = 1'b1;
      press = '0;
      steps(8);

      // Random key activity with random acks and rare resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 3))
               0:       press = '0;
               3:       press = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
               default: press = 16'(1) << $urandom_range(0, 15);
            endcase
         end
         key_ack = ($urandom_range(0, 15) == 0);
         rst     = ($urandom_range(0, 999) != 0);
         step();
      end
      key_ack = 1'b0;
      rst     = 1'b1;
      press   = '0;
      steps(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
